// File: rtl/key_hold_data_ctrl_if.sv
// Key/data bundle between board keys/switches and key_hold_data_ctrl.
// The controller takes the slave view; the driving side takes the master view.
interface key_hold_data_ctrl_if #(
  parameter int unsigned DATA_W = 4
);
  logic              en_key;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] out_data;
  logic              key_db;
  logic              short_pulse;
  logic              long_pulse;
  logic              busy;

  modport master (
    output en_key, mode, data,
    input  out_data, key_db, short_pulse, long_pulse, busy
  );

  modport slave (
    input  en_key, mode, data,
    output out_data, key_db, short_pulse, long_pulse, busy
  );
endinterface

// File: rtl/key_hold_data_ctrl.sv
// Key synchroniser, debouncer, short/long press classifier and data transform.
// Optional auto-repeat of the long-press action while held: KEY_AUTO_REPEAT_EN.
module key_hold_data_ctrl #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned HOLD_CYC   = 150000000,
  parameter int unsigned DEB_CYC    = 1000000,
  parameter int unsigned REPEAT_CYC = 25000000,
  parameter int unsigned CNT_W      = 28
) (
  input  logic                  FPGA_CLK,
  input  logic                  rst_n,
  key_hold_data_ctrl_if.slave   bus
);

  localparam int unsigned MAX_CNT = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned DEB_W   = $clog2(DEB_CYC + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  if ((64'd1 << CNT_W) <= 64'(MAX_CNT)) begin : g_cnt_w_check
    $error("CNT_W too narrow for HOLD_CYC/REPEAT_CYC");
  end

  typedef enum logic [1:0] {
    IDLE,
    TIMING,
    FIRED
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_key_s;
  logic              r_key_db;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]  w_hold_cnt_nxt;
  logic              r_inv_state;
  logic [DATA_W-1:0] r_out_data;
  logic              w_short;
  logic              w_long;

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] w_rep_cnt_nxt;
`endif

  // Two-flop synchroniser followed by a stability counter on the synced level.
  always_ff @(posedge FPGA_CLK) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_key_s   <= 1'b0;
      r_key_db  <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.en_key;
      r_key_s <= r_sync1;
      if (r_key_s == r_key_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_key_db  <= r_key_s;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
`ifdef KEY_AUTO_REPEAT_EN
      r_rep_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
`ifdef KEY_AUTO_REPEAT_EN
      r_rep_cnt  <= w_rep_cnt_nxt;
`endif
    end
  end

  // Release is tested before the threshold so a coincident release counts as short.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_short        = 1'b0;
    w_long         = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    w_rep_cnt_nxt  = r_rep_cnt;
`endif
    case (r_state)
      IDLE: begin
        w_hold_cnt_nxt = '0;
        if (r_key_db) begin
          w_state_nxt = TIMING;
        end
      end
      TIMING: begin
        if (!r_key_db) begin
          w_short        = 1'b1;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_long      = 1'b1;
          w_state_nxt = FIRED;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      FIRED: begin
        if (!r_key_db) begin
          w_hold_cnt_nxt = '0;
          w_state_nxt    = IDLE;
`ifdef KEY_AUTO_REPEAT_EN
          w_rep_cnt_nxt  = '0;
        end else if (r_rep_cnt == REP_LAST) begin
          w_long        = 1'b1;
          w_rep_cnt_nxt = '0;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + 1'b1;
`endif
        end
      end
      default: begin
        w_hold_cnt_nxt = '0;
        w_state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge FPGA_CLK) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_inv_state <= 1'b0;
    end else if (w_long) begin
      case (bus.mode)
        2'b00: r_out_data <= bus.data;
        2'b01: r_out_data <= ~bus.data;
        2'b10: begin
          r_out_data  <= bus.data ^ {DATA_W{~r_inv_state}};
          r_inv_state <= ~r_inv_state;
        end
        default: begin
          r_out_data  <= '0;
          r_inv_state <= 1'b0;
        end
      endcase
    end
  end

  // Pulses are gated so nothing escapes while reset is asserted.
  assign bus.out_data    = r_out_data;
  assign bus.key_db      = r_key_db;
  assign bus.short_pulse = w_short & rst_n;
  assign bus.long_pulse  = w_long & rst_n;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_key_hold_data_ctrl.sv
// Randomised self-checking bench for key_hold_data_ctrl against a press-length model.
// Honours KEY_AUTO_REPEAT_EN in the same way as the design.
module tb_key_hold_data_ctrl;

  localparam int unsigned DW   = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned DEB  = 3;
  localparam int unsigned REP  = 4;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_hold_data_ctrl_if #(.DATA_W(DW)) bus ();

  key_hold_data_ctrl #(
    .DATA_W    (DW),
    .HOLD_CYC  (HOLD),
    .DEB_CYC   (DEB),
    .REPEAT_CYC(REP),
    .CNT_W     (28)
  ) dut (
    .FPGA_CLK(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: synchroniser, run of differing cycles, run of debounced-high cycles.
  logic          m_s1 = 0, m_ks = 0, m_db = 0, m_inv = 0;
  int            m_diff = 0, m_ones = 0;
  logic [DW-1:0] exp_out = '0;
  logic          exp_short = 0, exp_long = 0, exp_busy = 0;
  int            n_short = 0, n_long = 0;

  function automatic logic [7:0] obs();
    return {bus.out_data, bus.key_db, bus.short_pulse, bus.long_pulse, bus.busy};
  endfunction

  function automatic logic [7:0] expv();
    return {exp_out, m_db, exp_short, exp_long, exp_busy};
  endfunction

  // One clock: drive inputs, advance to just after the edge, advance the model.
  task automatic step(input logic en, input logic [1:0] md, input logic [DW-1:0] dt,
                      input logic rn);
    int j;
    bus.en_key = en;
    bus.mode   = md;
    bus.data   = dt;
    rst_n      = rn;
    @(posedge clk);
    #1;
    if (!rn) begin
      m_s1 = 0; m_ks = 0; m_db = 0; m_inv = 0; m_diff = 0; m_ones = 0;
      exp_out = '0; exp_short = 0; exp_long = 0; exp_busy = 0;
    end else begin
      if (exp_long) begin
        case (md)
          2'b00: exp_out = dt;
          2'b01: exp_out = ~dt;
          2'b10: begin exp_out = m_inv ? dt : ~dt; m_inv = ~m_inv; end
          default: begin exp_out = '0; m_inv = 0; end
        endcase
      end
      if (m_ks != m_db) begin
        m_diff++;
        if (m_diff == DEB) begin m_db = m_ks; m_diff = 0; end
      end else begin
        m_diff = 0;
      end
      m_ks = m_s1;
      m_s1 = en;
      exp_busy  = (m_ones > 0);
      exp_short = 0;
      exp_long  = 0;
      if (m_db) begin
        m_ones++;
        j = m_ones - 1;
        exp_long = (j == HOLD) ||
                   (REP_ON && j > HOLD && ((j - HOLD) % REP) == 0);
      end else begin
        exp_short = (m_ones >= 1 && m_ones <= HOLD);
        m_ones = 0;
      end
    end
    if (bus.short_pulse === 1'b1) n_short++;
    if (bus.long_pulse === 1'b1) n_long++;
  endtask

  task automatic test_reset();
    int rise;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b00, 4'hA, 1'b0);
      n_checks++;
      if (obs() !== 8'h00) $display("FAIL reset_outputs cyc%0d got=%h want=00", i, obs());
      else n_pass++;
    end
    rise = 0;
    for (int i = 1; i <= 20 && rise == 0; i++) begin
      step(1'b1, 2'b00, 4'hA, 1'b1);
      if (bus.key_db === 1'b1) rise = i;
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_release cyc%0d got=%h want=%h", i, obs(), expv());
      else n_pass++;
    end
    n_checks++;
    if (rise != 5) $display("FAIL reset_db_latency got=%0d want=5", rise);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b00, 4'hA, 1'b1);
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_settle cyc%0d got=%h want=%h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic bad;
    bad = 0;
    n_short = 0; n_long = 0;
    for (int i = 0; i < 12; i++) begin
      step((i < 2), 2'b01, 4'h6, 1'b1);
      if (bus.key_db !== 1'b0 || bus.busy !== 1'b0) bad = 1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL glitch cyc%0d got=%h want=%h", i, obs(), expv());
      else n_pass++;
    end
    n_checks++;
    if (bad || n_short != 0 || n_long != 0)
      $display("FAIL glitch_reject got db/busy_seen=%0d short=%0d long=%0d want 0/0/0", bad, n_short, n_long);
    else n_pass++;
  endtask

  task automatic press(input int hold, input logic [1:0] md, input logic [DW-1:0] dt, input string nm);
    for (int i = 0; i < hold + 12; i++) begin
      step((i < hold), md, dt, 1'b1);
      n_checks++;
      if (obs() !== expv()) $display("FAIL %s cyc%0d got=%h want=%h", nm, i, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_short();
    n_short = 0; n_long = 0;
    press(6, 2'b01, 4'($urandom), "short");
    n_checks++;
    if (n_short != 1 || n_long != 0 || bus.out_data !== 4'h0)
      $display("FAIL short_press got short=%0d long=%0d out=%h want 1/0/0", n_short, n_long, bus.out_data);
    else n_pass++;
  endtask

  task automatic test_long();
    n_long = 0;
    press(14, 2'b01, 4'hA, "long_inv");
    n_checks++;
    if (n_long != 1 || bus.out_data !== 4'h5)
      $display("FAIL long_invert got long=%0d out=%h want 1/5", n_long, bus.out_data);
    else n_pass++;
    n_long = 0;
    press(14, 2'b11, 4'($urandom), "long_clr");
    n_checks++;
    if (n_long != 1 || bus.out_data !== 4'h0)
      $display("FAIL long_clear got long=%0d out=%h want 1/0", n_long, bus.out_data);
    else n_pass++;
    press(14, 2'b00, 4'h9, "long_load");
    n_checks++;
    if (bus.out_data !== 4'h9) $display("FAIL long_load got out=%h want 9", bus.out_data);
    else n_pass++;
  endtask

  task automatic test_toggle();
    press(12, 2'b11, 4'h0, "toggle_pre");
    press(12, 2'b10, 4'h3, "toggle1");
    n_checks++;
    if (bus.out_data !== 4'hC) $display("FAIL toggle_first got out=%h want C", bus.out_data);
    else n_pass++;
    press(12, 2'b10, 4'h3, "toggle2");
    n_checks++;
    if (bus.out_data !== 4'h3) $display("FAIL toggle_second got out=%h want 3", bus.out_data);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int want;
    want = REP_ON ? 3 : 1;
    n_long = 0;
    press(19, 2'b10, 4'h3, "repeat");
    n_checks++;
    if (n_long != want || bus.out_data !== 4'hC)
      $display("FAIL repeat_hold got long=%0d out=%h want %0d/C", n_long, bus.out_data, want);
    else n_pass++;
  endtask

  task automatic test_random();
    logic en;
    int   seg;
    en  = 1'b0;
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        en  = ~en;
        seg = (($urandom % 4) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 9);
      end
      seg--;
      step(en, 2'($urandom), 4'($urandom), (($urandom % 250) != 0));
      n_checks++;
      if (obs() !== expv()) $display("FAIL random cyc%0d got=%h want=%h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en_key = 1'b0;
    bus.mode   = 2'b00;
    bus.data   = '0;
    test_reset();
    test_glitch();
    test_short();
    test_long();
    test_toggle();
    test_repeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
